carry_select_adder_64b: RTL and testbench
=========================================

// Module: carry_select_adder_64b
// PURPOSE
//  - 64-bit two-operand adder with carry-in, built as a carry-select structure, with a registered output.
//  - Operand is split into fixed-width blocks. Each block (except block 0) precomputes sum/carry for
//    carry-in 0 and 1 in parallel; the true incoming carry then muxes the result.
//  - Arithmetic leaf in the multiplier datapath (final carry-propagate adder after reduction).
// PARAMETERS
//  - BLOCK_W  4  bits per carry-select block; must divide 64 (legal: 4, 8, 16).
//  - Total width is fixed at 64 and is not a parameter.
// PORTS
//  - clk   in   1   clock; all state on rising edge
//  - rst   in   1   synchronous, active-high reset
//  - in1   in   64  operand A, unsigned
//  - in2   in   64  operand B, unsigned
//  - cin   in   1   carry-in
//  - sum   out  64  registered (in1 + in2 + cin) mod 2^64
//  - cout  out  1   registered carry-out (bit 64 of the full sum)
// BEHAVIOUR
//  - Reset: on a rising clk with rst=1, sum <= 64'h0 and cout <= 0. Reset takes priority over any
//    input; in-flight results are discarded.
//  - Datapath:
//    - Block 0 is a plain ripple-carry adder fed by cin.
//    - Blocks 1..N-1 (N = 64/BLOCK_W) each contain two ripple adders (carry-in 0 and carry-in 1).
//      The selected carry-out of block k-1 picks that block's sum and carry.
//    - The last block's selected carry is cout.
//  - Result: {cout, sum} == in1 + in2 + cin exactly (65-bit unsigned). No saturation and no
//    overflow flag.
//  - Latency: 1 cycle. Inputs sampled at edge t appear on sum/cout after edge t and hold until the
//    next edge. There is no handshake; a new operand pair is accepted every cycle.
//  - Boundaries:
//    - all-ones + 0 + cin=1 wraps to sum=0, cout=1.
//    - A carry rippling through every block must resolve within one cycle.
//  - No X propagation from unused internals; every output bit is driven from a flop.
// CONFIGURATION
//  - CSA_INPUT_REG_EN:
//    - Defined: in1/in2/cin are first captured in an input register stage (reset to 0), then the
//      combinational adder feeds the output register. Latency is 2 cycles. Reset clears both stages.
//    - Undefined: single output register only; latency is 1 cycle.
// TESTING (latency L = 1, or 2 with CSA_INPUT_REG_EN; check L cycles after apply)
//  - rst=1 for 2 cycles with nonzero inputs -> sum=0, cout=0 throughout reset.
//  - in1=64'h1, in2=64'h0, cin=0 -> sum=64'h1, cout=0.
//  - in1=64'h1010, in2=64'h11, cin=0 -> sum=64'h1021, cout=0.
//  - in1=64'h1101000000000000, in2=64'h1010000000000000, cin=1 -> sum=64'h2111000000000001, cout=0.
//  - Full carry chain: in1=64'hFFFFFFFFFFFFFFFF, in2=0, cin=1 -> sum=0, cout=1.
//    Also in1=in2=64'hFFFFFFFFFFFFFFFF, cin=1 -> sum=64'hFFFFFFFFFFFFFFFF, cout=1.
//  - Back-to-back vectors every cycle, with rst asserted mid-stream:
//    - outputs track each vector at latency L;
//    - the cycle after rst shows sum=0/cout=0, and results resume L cycles after release;
//    - random compare against {cout,sum} = in1+in2+cin for BLOCK_W = 4, 8 and 16.

Source files
------------

// File: rtl/carry_select_adder_64b.sv
// 64-bit carry-select adder with carry-in and registered {cout, sum}; BLOCK_W must divide 64 (4, 8, 16).
// Optional macro CSA_INPUT_REG_EN adds an input register stage (latency 2 instead of 1).
module carry_select_adder_64b #(
    parameter int BLOCK_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in1,
    input  logic [63:0] in2,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    localparam int NUM_BLK = 64 / BLOCK_W;

    // Explicit bit-serial ripple so each block stays a true ripple chain.
    function automatic logic [BLOCK_W:0] ripple(
        input logic [BLOCK_W-1:0] a,
        input logic [BLOCK_W-1:0] b,
        input logic               c
    );
        logic [BLOCK_W-1:0] s;
        logic               cy;
        cy = c;
        for (int i = 0; i < BLOCK_W; i++) begin
            s[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        return {cy, s};
    endfunction

    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        op_c;

`ifdef CSA_INPUT_REG_EN
    logic [63:0] a_reg;
    logic [63:0] b_reg;
    logic        c_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= 64'h0;
            b_reg <= 64'h0;
            c_reg <= 1'b0;
        end else begin
            a_reg <= in1;
            b_reg <= in2;
            c_reg <= cin;
        end
    end

    assign op_a = a_reg;
    assign op_b = b_reg;
    assign op_c = c_reg;
`else
    assign op_a = in1;
    assign op_b = in2;
    assign op_c = cin;
`endif

    logic [63:0] sum_next;
    logic        cout_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BLK; gi++) begin : g_blk
            localparam int LO = gi * BLOCK_W;
            logic [BLOCK_W-1:0] a_blk;
            logic [BLOCK_W-1:0] b_blk;
            logic [BLOCK_W-1:0] s_blk;
            logic               c_in;
            logic               c_out;

            assign a_blk = op_a[LO +: BLOCK_W];
            assign b_blk = op_b[LO +: BLOCK_W];

            if (gi == 0) begin : g_first
                assign c_in           = op_c;
                assign {c_out, s_blk} = ripple(a_blk, b_blk, c_in);
            end else begin : g_sel
                // Both candidate results are ready before the incoming carry settles.
                logic [BLOCK_W:0] res0;
                logic [BLOCK_W:0] res1;
                assign res0           = ripple(a_blk, b_blk, 1'b0);
                assign res1           = ripple(a_blk, b_blk, 1'b1);
                assign c_in           = g_blk[gi-1].c_out;
                assign {c_out, s_blk} = c_in ? res1 : res0;
            end

            assign sum_next[LO +: BLOCK_W] = s_blk;
        end
    endgenerate

    assign cout_next = g_blk[NUM_BLK-1].c_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= 64'h0;
            cout <= 1'b0;
        end else begin
            sum  <= sum_next;
            cout <= cout_next;
        end
    end

endmodule

// File: tb/tb_carry_select_adder_64b.sv
// Scoreboard bench for carry_select_adder_64b: three instances (BLOCK_W 4/8/16) checked against 65-bit arithmetic.
module tb_carry_select_adder_64b;

`ifdef CSA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in1;
    logic [63:0] in2;
    logic        cin;
    logic [63:0] sum_w4, sum_w8, sum_w16;
    logic        cout_w4, cout_w8, cout_w16;

    always #5 clk = ~clk;

    carry_select_adder_64b #(.BLOCK_W(4)) dut_w4 (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .cin(cin), .sum(sum_w4), .cout(cout_w4));
    carry_select_adder_64b #(.BLOCK_W(8)) dut_w8 (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .cin(cin), .sum(sum_w8), .cout(cout_w8));
    carry_select_adder_64b #(.BLOCK_W(16)) dut_w16 (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .cin(cin), .sum(sum_w16), .cout(cout_w16));

    typedef struct {
        logic        rst;
        logic [64:0] exp;
        int          idx;
    } item_t;

    item_t sb_q[$];
    int    errors  = 0;
    int    checks  = 0;
    int    issued  = 0;
    bit    done    = 1'b0;

    // Drive one vector for the coming rising edge and record its arithmetic result.
    task automatic apply(input logic r, input logic [63:0] a, input logic [63:0] b, input logic c);
        item_t it;
        @(negedge clk);
        rst = r;
        in1 = a;
        in2 = b;
        cin = c;
        it.rst = r;
        it.exp = {1'b0, a} + {1'b0, b} + {64'd0, c};
        it.idx = issued;
        issued++;
        sb_q.push_back(it);
    endtask

    task automatic check_one(input string name, input int idx, input logic [64:0] got, input logic [64:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s vec=%0d got={%0b,%h} want={%0b,%h}", name, idx, got[64], got[63:0], want[64], want[63:0]);
        end else begin
            $display("ok   %s vec=%0d {%0b,%h}", name, idx, got[64], got[63:0]);
        end
    endtask

    // Monitor: the result of the vector applied LAT edges ago is visible now, unless a reset
    // was applied on any of those LAT edges.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!done && sb_q.size() > 0) begin
                logic [64:0] want;
                int          idx;
                logic        any_rst;
                bit          do_check;
                any_rst  = 1'b0;
                do_check = 1'b0;
                want     = 65'd0;
                idx      = sb_q[sb_q.size()-1].idx;
                if (sb_q.size() >= LAT) begin
                    for (int i = 0; i < LAT; i++) any_rst |= sb_q[i].rst;
                    want     = any_rst ? 65'd0 : sb_q[0].exp;
                    idx      = sb_q[0].idx;
                    do_check = 1'b1;
                    void'(sb_q.pop_front());
                end else if (sb_q[sb_q.size()-1].rst) begin
                    do_check = 1'b1;
                end
                if (do_check) begin
                    check_one("bw4",  idx, {cout_w4,  sum_w4},  want);
                    check_one("bw8",  idx, {cout_w8,  sum_w8},  want);
                    check_one("bw16", idx, {cout_w16, sum_w16}, want);
                end
            end
        end
    end

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] ones;
        ones = 64'hFFFF_FFFF_FFFF_FFFF;
        rst = 1'b1;
        in1 = 64'h0;
        in2 = 64'h0;
        cin = 1'b0;

        // Reset held with nonzero inputs.
        apply(1'b1, 64'hDEAD_BEEF_0000_1234, 64'h1111_2222_3333_4444, 1'b1);
        apply(1'b1, 64'hDEAD_BEEF_0000_1234, 64'h1111_2222_3333_4444, 1'b1);

        // Directed vectors, back to back.
        apply(1'b0, 64'h1, 64'h0, 1'b0);
        apply(1'b0, 64'h1010, 64'h11, 1'b0);
        apply(1'b0, 64'h1101_0000_0000_0000, 64'h1010_0000_0000_0000, 1'b1);
        apply(1'b0, ones, 64'h0, 1'b1);
        apply(1'b0, ones, ones, 1'b1);
        apply(1'b0, ones, 64'h1, 1'b0);
        apply(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        apply(1'b0, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 1'b1);

        // Mid-stream reset pulse, then resume.
        apply(1'b1, 64'h1234, 64'h5678, 1'b1);
        apply(1'b0, 64'h7, 64'h9, 1'b0);
        apply(1'b0, ones, 64'h0, 1'b1);

        // Randomised back-to-back stream with occasional resets and carry-heavy patterns.
        for (int n = 0; n < 300; n++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0: b = ~a;
                1: a = ones;
                2: b = 64'h0;
                default: ;
            endcase
            apply(($urandom_range(0, 31) == 0), a, b, 1'($urandom_range(0, 1)));
        end

        // Flush the pipeline so every issued vector gets compared.
        for (int n = 0; n < LAT; n++) apply(1'b1, 64'h0, 64'h0, 1'b0);
        @(posedge clk);
        #2;
        done = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
